stream_bit_unpacker: RTL and testbench

- Parametrised successor of the fixed-width stream aligner: unpacks variable-length bit fields (1..OUT_W bits, LSB-first) from a framed IN_W-bit word stream.
- Adds the capabilities the aligner lacks:
  - full valid/ready on both sides;
  - per-field length with clean packet boundaries;
  - short final field and optional byte re-alignment.
- Sits between the packet DMA/word stream and header/field parsers.

---
 rtl/stream_align_pkg.sv | 17 +
 rtl/stream_shift_merge.sv | 20 ++
 rtl/stream_bit_unpacker.sv | 83 ++++++++
 tb/tb_stream_bit_unpacker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_align_pkg.sv
// stream_align_pkg: shared default widths and field/byte-alignment helpers for the stream bit unpacker and packers
package stream_align_pkg;
   localparam int IN_W_D   = 128;
   localparam int OUT_W_D  = 32;
   localparam int LEN_W_D  = $clog2(OUT_W_D + 1);
   localparam int CNT_W_D  = $clog2(2 * IN_W_D + 1);
   // widest field any user may request; callers cast the mask down to their OUT_W
   localparam int MASK_MAX = 256;
   // low len bits set
   function automatic logic [MASK_MAX-1:0] field_mask(input int unsigned len);
      return ~({MASK_MAX{1'b1}} << len);
   endfunction
   // bits left until the next byte boundary after consuming take bits from offset pos
   function automatic logic [2:0] byte_pad(input logic [2:0] pos, input int unsigned take);
      return 3'(3'd0 - (pos + 3'(take)));
   endfunction
endpackage

// File: rtl/stream_shift_merge.sv
// stream_shift_merge: drops shift_i bits off the bottom of buf_i and ORs data_i in at bit offset off_i
// ports: buf_i/buf_o 2*IN_W buffer in/out, shift_i bits consumed, data_i new word, off_i write offset, wr_i write enable
module stream_shift_merge import stream_align_pkg::*; #(
   parameter int IN_W  = IN_W_D,
   parameter int CNT_W = CNT_W_D
) (
   input  logic [2*IN_W-1:0] buf_i,
   input  logic [CNT_W-1:0]  shift_i,
   input  logic [IN_W-1:0]   data_i,
   input  logic [CNT_W-1:0]  off_i,
   input  logic              wr_i,
   output logic [2*IN_W-1:0] buf_o
);
   logic [2*IN_W-1:0] word_ext;
   // bits above the fill level are always zero, so a plain OR merges cleanly
   always_comb begin
      word_ext = wr_i ? {{IN_W{1'b0}}, data_i} : '0;
      buf_o    = (buf_i >> shift_i) | (word_ext << off_i);
   end
endmodule

// File: rtl/stream_bit_unpacker.sv
// stream_bit_unpacker: unpacks LSB-first variable-length fields (1..OUT_W bits) from a framed IN_W-bit word stream
// ports: s_* input word stream (valid/ready, sop/eop), m_len/m_align field request, m_* field out (valid/ready,
//        data, sop, eop, short), level buffered bit count; clk rising edge, rst synchronous active-high
module stream_bit_unpacker import stream_align_pkg::*; #(
   parameter int IN_W    = IN_W_D,
   parameter int OUT_W   = OUT_W_D,
   parameter int LEN_W   = $clog2(OUT_W + 1),
   localparam int CNT_W  = $clog2(2 * IN_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [IN_W-1:0]  s_data,
   input  logic             s_sop,
   input  logic             s_eop,
   input  logic [LEN_W-1:0] m_len,
   input  logic             m_align,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OUT_W-1:0] m_data,
   output logic             m_sop,
   output logic             m_eop,
   output logic             m_short,
   output logic [CNT_W-1:0] level
);
   logic [2*IN_W-1:0] buf_q, buf_d, merge_buf;
   logic [CNT_W-1:0]  cnt_q, cnt_d, len, take, pad, used, base, rest;
   logic [2:0]        pos_q, pos_d, pad3;
   logic              eop_pend_q, eop_pend_d, sop_pend_q, sop_pend_d, err_q, err_d;
   logic              acc, xfer, new_pkt;
   always_comb begin
      len        = (m_len > LEN_W'(OUT_W)) ? CNT_W'(OUT_W) : CNT_W'(m_len);
      take       = (len < cnt_q) ? len : cnt_q;
      rest       = cnt_q - take;
      pad3       = byte_pad(pos_q, 32'(take));
      pad        = !m_align ? '0 : (CNT_W'(pad3) < rest) ? CNT_W'(pad3) : rest;
      s_ready    = (cnt_q <= CNT_W'(IN_W)) & !eop_pend_q;
      m_valid    = (len != 0) & ((cnt_q >= len) | (eop_pend_q & (cnt_q != 0)));
      m_data     = buf_q[OUT_W-1:0] & OUT_W'(field_mask(32'(take)));
      m_sop      = sop_pend_q;
      m_eop      = eop_pend_q & (len != 0) & (take + pad == cnt_q);
      m_short    = eop_pend_q & (cnt_q < len);
      level      = cnt_q;
      acc        = s_valid & s_ready;
      xfer       = m_valid & m_ready;
      new_pkt    = acc & s_sop;
      used       = xfer ? take + pad : '0;
      // a new packet always starts from an empty buffer; any unterminated residue is discarded
      base       = new_pkt ? '0 : cnt_q - used;
      merge_buf  = new_pkt ? '0 : buf_q;
      cnt_d      = base + (acc ? CNT_W'(IN_W) : '0);
      pos_d      = new_pkt ? 3'd0 : pos_q + 3'(used);
      sop_pend_d = new_pkt | (sop_pend_q & !xfer);
      eop_pend_d = (acc & s_eop) | (eop_pend_q & (cnt_d != 0));
      err_d      = err_q | (new_pkt & (cnt_q != 0));
   end
   stream_shift_merge #(.IN_W(IN_W), .CNT_W(CNT_W)) u_merge (
      .buf_i   (merge_buf),
      .shift_i (used),
      .data_i  (s_data),
      .off_i   (base),
      .wr_i    (acc),
      .buf_o   (buf_d)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q      <= '0;
         cnt_q      <= '0;
         pos_q      <= '0;
         eop_pend_q <= 1'b0;
         sop_pend_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         cnt_q      <= cnt_d;
         pos_q      <= pos_d;
         eop_pend_q <= eop_pend_d;
         sop_pend_q <= sop_pend_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_stream_bit_unpacker.sv
// tb_stream_bit_unpacker: directed self-checking bench for stream_bit_unpacker
module tb_stream_bit_unpacker;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0, s_ready, s_sop = 1'b0, s_eop = 1'b0;
   logic [127:0] s_data = '0;
   logic [5:0]   m_len = '0;
   logic         m_align = 1'b0, m_valid, m_ready = 1'b0, m_sop, m_eop, m_short;
   logic [31:0]  m_data;
   logic [8:0]   level;
   int n_checks = 0, n_err = 0;
   logic [31:0]  e1 [11] = '{32'h210, 32'h543, 32'h876, 32'hBA9, 32'hEDC, 32'h77F,
                             32'h566, 32'h445, 32'h233, 32'h112, 32'hA5};
   logic [127:0] w2 [2] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100,
                            128'h1F1E1D1C_1B1A1918_17161514_13121110};
   stream_bit_unpacker dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_sop(s_sop), .s_eop(s_eop), .m_len(m_len), .m_align(m_align), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_short(m_short),
      .level(level)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int k, widx;
      logic hs_s, hs_m;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_len = 6'd12;
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_flags", {m_sop, m_eop, m_short}, 0);
      check("rst_level", level, 0);
      check("rst_s_ready", s_ready, 1);
      // single-word packet, 12-bit fields
      s_valid = 1; s_data = 128'hA5112233_44556677_FEDCBA98_76543210; s_sop = 1; s_eop = 1;
      @(negedge clk);
      s_valid = 0; s_sop = 0; s_eop = 0;
      #1;
      check("t1_level", level, 128);
      check("t1_s_ready_low", s_ready, 0);
      m_ready = 1;
      for (int i = 0; i < 11; i++) begin
         #1;
         check($sformatf("t1_field%0d", i), m_data, e1[i]);
         check($sformatf("t1_sop%0d", i), m_sop, i == 0);
         check($sformatf("t1_eop_short%0d", i), {m_eop, m_short}, (i == 10) ? 2'b11 : 2'b00);
         @(negedge clk);
      end
      #1;
      check("t1_empty", level, 0);
      check("t1_s_ready_back", s_ready, 1);
      // two-word packet, 32-bit fields, consumer toggling ready
      m_len = 6'd32;
      k = 0; widx = 0;
      for (int c = 0; c < 40; c++) begin
         s_valid = widx < 2; s_data = w2[widx & 1]; s_sop = widx == 0; s_eop = widx == 1;
         m_ready = c[0];
         #1;
         check("t2_level_max", level > 256, 0);
         check("t2_ready_gate", s_ready & (level > 128), 0);
         hs_s = s_valid & s_ready;
         hs_m = m_valid & m_ready;
         if (hs_m) begin
            check($sformatf("t2_field%0d", k), m_data, w2[k / 4][32 * (k % 4) +: 32]);
            check($sformatf("t2_sop_eop%0d", k), {m_sop, m_eop}, {k == 0, k == 7});
            k++;
         end
         @(negedge clk);
         if (hs_s) widx++;
      end
      s_valid = 0; s_sop = 0; s_eop = 0; m_ready = 0;
      #1;
      check("t2_fields", k, 8);
      check("t2_empty", level, 0);
      // byte re-alignment after a 3-bit field, then align discard empties the packet
      s_valid = 1; s_data = 128'hDEADBEEF_CAFEF00D_12345678_9ABC3CA5; s_sop = 1; s_eop = 1;
      m_len = 6'd3; m_align = 1;
      @(negedge clk);
      s_valid = 0; s_sop = 0; s_eop = 0;
      #1;
      check("t3_f0", m_data, 32'h5);
      check("t3_f0_valid", m_valid, 1);
      m_ready = 1;
      @(negedge clk);
      m_align = 0; m_len = 6'd8;
      #1;
      check("t3_level_after_pad", level, 120);
      check("t3_f1", m_data, 32'h3C);
      @(negedge clk);
      m_len = 6'd32;
      #1;
      check("t3_f2", m_data, 32'h56789ABC);
      @(negedge clk);
      #1;
      check("t3_f3", m_data, 32'hF00D1234);
      @(negedge clk);
      #1;
      check("t3_f4", m_data, 32'hBEEFCAFE);
      @(negedge clk);
      m_len = 6'd12; m_align = 1;
      #1;
      check("t3_level16", level, 16);
      check("t3_f5", m_data, 32'hEAD);
      check("t3_align_eop", {m_eop, m_short}, 2'b10);
      @(negedge clk);
      m_align = 0;
      #1;
      check("t3_empty", level, 0);
      check("t3_s_ready", s_ready, 1);
      // accept and transfer together at cnt=128, then a field across the word boundary
      m_ready = 0; m_len = 6'd20;
      s_valid = 1; s_data = 128'hA1112233_44556677_8899AABB_CCDDEEFF; s_sop = 1; s_eop = 0;
      @(negedge clk);
      s_data = 128'hFFEEDDCC_BBAA9988_77665544_33221100; s_sop = 0;
      m_ready = 1;
      #1;
      check("t4_level128", level, 128);
      check("t4_s_ready", s_ready, 1);
      check("t4_f0", m_data, 32'hDEEFF);
      @(negedge clk);
      s_valid = 0;
      #1;
      check("t4_level236", level, 236);
      check("t4_s_ready_low", s_ready, 0);
      check("t4_f1", m_data, 32'hBBCCD);
      repeat (5) @(negedge clk);
      #1;
      check("t4_level136", level, 136);
      check("t4_span", m_data, 32'h100A1);
      @(negedge clk);
      m_ready = 0;
      #1;
      check("t4_level116", level, 116);
      // new packet start while the old one never ended: residue dropped
      m_len = 6'd32;
      s_valid = 1; s_data = 128'h11111111_22222222_33333333_5EED1234; s_sop = 1; s_eop = 0;
      #1;
      check("t5_s_ready", s_ready, 1);
      @(negedge clk);
      s_valid = 0; s_sop = 0;
      #1;
      check("t5_level", level, 128);
      check("t5_sop", m_sop, 1);
      check("t5_f0", m_data, 32'h5EED1234);
      check("t5_err", dut.err_q, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_data", m_data, 0);
      check("t5_rst_flags", {m_sop, m_eop, m_short}, 0);
      check("t5_rst_level", level, 0);
      check("t5_rst_s_ready", s_ready, 1);
      check("t5_rst_err", dut.err_q, 0);
      // zero-length request and over-length clamp
      m_len = 6'd0; m_ready = 1;
      s_valid = 1; s_data = 128'hCAFEBABE_01234567_89ABCDEF_76543210; s_sop = 1; s_eop = 1;
      @(negedge clk);
      s_valid = 0; s_sop = 0; s_eop = 0;
      #1;
      check("t6_len0_valid", m_valid, 0);
      @(negedge clk);
      #1;
      check("t6_len0_hold", level, 128);
      m_len = 6'd40;
      #1;
      check("t6_clamp_valid", m_valid, 1);
      check("t6_clamp_f0", m_data, 32'h76543210);
      check("t6_clamp_sop", {m_sop, m_short}, 2'b10);
      @(negedge clk);
      #1;
      check("t6_level96", level, 96);
      check("t6_f1", m_data, 32'h89ABCDEF);
      check("t6_sop_clear", m_sop, 0);
      m_len = 6'd32;
      @(negedge clk);
      #1;
      check("t6_f2", m_data, 32'h01234567);
      @(negedge clk);
      #1;
      check("t6_f3", m_data, 32'hCAFEBABE);
      check("t6_eop", {m_eop, m_short}, 2'b10);
      @(negedge clk);
      #1;
      check("t6_empty", level, 0);
      check("t6_s_ready", s_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
